// File: rtl/aes_key_expander_if.sv
// rtl/aes_key_expander_if.sv - cipher key in / round key out handshake bundle
interface aes_key_expander_if;
  logic         key_valid;
  logic [127:0] key;
  logic         key_ready;
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic [127:0] round_key;

  modport master (
    output key_valid, key,
    input  key_ready, rk_valid, rk_round, round_key
  );

  modport slave (
    input  key_valid, key,
    output key_ready, rk_valid, rk_round, round_key
  );
endinterface

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - iterative AES-128 key schedule, one round key per clock
module aes_key_expander (
  input  logic              clk,
  input  logic              reset,
  aes_key_expander_if.slave bus
);
  typedef enum logic {IDLE, EXPAND} state_t;

  // Forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] rk_q, rk_d;
  logic         valid_q, valid_d;

  logic         ready;
  logic         accept;
  logic [31:0]  w0, w1, w2, w3, temp;
  logic [31:0]  n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk_q;
  assign temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
              ^ {rcon_q, 24'h000000};
  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  // Ready on the last round lets the next key follow without a bubble.
  assign ready  = (state_q == IDLE) || (rnd_q == 4'd10);
  assign accept = bus.key_valid && ready;

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    rk_d    = rk_q;
    valid_d = valid_q;
    if (accept) begin
      state_d = EXPAND;
      rnd_d   = 4'd0;
      rcon_d  = 8'h01;
      rk_d    = bus.key;
      valid_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        EXPAND: begin
          if (rnd_q < 4'd10) begin
            rk_d   = {n0, n1, n2, n3};
            rnd_d  = rnd_q + 4'd1;
            rcon_d = xtime(rcon_q);
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      rcon_q  <= 8'h01;
      rk_q    <= 128'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      rk_q    <= rk_d;
      valid_q <= valid_d;
    end
  end

  assign bus.key_ready = ready;
  assign bus.rk_valid  = valid_q;
  assign bus.rk_round  = rnd_q;
  assign bus.round_key = rk_q;
endmodule

// File: tb/tb_aes_key_expander.sv
// tb/tb_aes_key_expander.sv - scoreboard bench for aes_key_expander with FIPS-197 vectors
module tb_aes_key_expander;
  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] rk;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  logic [127:0] fips_rk [0:10];
  logic [127:0] zero_rk [0:10];
  logic [127:0] fips_key;

  always #5 clk = ~clk;

  aes_key_expander_if bus();
  aes_key_expander dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_fips(input int last);
    for (int i = 0; i <= last; i++) sb.push_back('{rnd: 4'(i), rk: fips_rk[i]});
  endtask

  task automatic push_zero();
    for (int i = 0; i <= 10; i++) sb.push_back('{rnd: 4'(i), rk: zero_rk[i]});
  endtask

  // Monitor: every presented round key must match the next scoreboard entry.
  always @(negedge clk) begin
    if (bus.rk_valid === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        check("unexpected_rk", {124'd0, bus.rk_round}, 128'hffff);
      end else begin
        e = sb.pop_front();
        check("rk_round", {124'd0, bus.rk_round}, {124'd0, e.rnd});
        check("round_key", bus.round_key, e.rk);
      end
    end
  end

  initial begin
    fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    zero_rk = '{
      128'h00000000000000000000000000000000, 128'h62636363626363636263636362636363,
      128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 128'h90973450696ccffaf2f457330b0fac99,
      128'hee06da7b876a1581759e42b27e91ee2b, 128'h7f2e2b88f8443e098dda7cbbf34b9290,
      128'hec614b851425758c99ff09376ab49ba7, 128'h217517873550620bacaf6b3cc61bf09b,
      128'h0ef903333ba9613897060a04511dfa9f, 128'hb1d4d8e28a7db9da1d7bb3de4c664941,
      128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    reset = 1'b1;
    bus.key_valid = 1'b0;
    bus.key = '0;
    step();
    check("reset_rk_valid", {127'd0, bus.rk_valid}, 128'd0);
    check("reset_rk_round", {124'd0, bus.rk_round}, 128'd0);
    check("reset_round_key", bus.round_key, 128'd0);
    check("reset_key_ready", {127'd0, bus.key_ready}, 128'd1);
    reset = 1'b0;
    step();

    // Single FIPS key.
    push_fips(10);
    bus.key = fips_key;
    bus.key_valid = 1'b1;
    step();
    bus.key_valid = 1'b0;
    for (int i = 1; i <= 10; i++) step();
    check("single_ready_t11", {127'd0, bus.key_ready}, 128'd1);
    step();
    check("single_valid_t12", {127'd0, bus.rk_valid}, 128'd0);
    step();

    // FIPS key followed back-to-back by the zero key held valid.
    push_fips(10);
    push_zero();
    bus.key = fips_key;
    bus.key_valid = 1'b1;
    step();
    bus.key = '0;
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("b2b_ready_t%0d", k), {127'd0, bus.key_ready}, 128'd0);
      step();
    end
    check("b2b_ready_t11", {127'd0, bus.key_ready}, 128'd1);
    step();
    bus.key_valid = 1'b0;
    for (int k = 12; k <= 22; k++) begin
      check($sformatf("b2b_valid_t%0d", k), {127'd0, bus.rk_valid}, 128'd1);
      step();
    end
    check("b2b_valid_t23", {127'd0, bus.rk_valid}, 128'd0);
    step();

    // A different key pulsed mid-expansion must be ignored.
    push_fips(10);
    bus.key = fips_key;
    bus.key_valid = 1'b1;
    step();
    bus.key_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    bus.key = 128'h00112233445566778899aabbccddeeff;
    bus.key_valid = 1'b1;
    step();
    bus.key_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    step();
    check("pulse_valid_t12", {127'd0, bus.rk_valid}, 128'd0);
    step();

    // Reset in the rk4 cycle, then a fresh FIPS expansion.
    push_fips(4);
    bus.key = fips_key;
    bus.key_valid = 1'b1;
    step();
    bus.key_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    check("midrst_rk_valid", {127'd0, bus.rk_valid}, 128'd0);
    check("midrst_rk_round", {124'd0, bus.rk_round}, 128'd0);
    check("midrst_round_key", bus.round_key, 128'd0);
    check("midrst_key_ready", {127'd0, bus.key_ready}, 128'd1);
    reset = 1'b0;
    push_fips(10);
    bus.key_valid = 1'b1;
    step();
    bus.key_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    step();
    check("midrst_valid_end", {127'd0, bus.rk_valid}, 128'd0);

    // Reset held with key_valid high: nothing accepted until release.
    reset = 1'b1;
    bus.key_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rsthold_valid_%0d", i), {127'd0, bus.rk_valid}, 128'd0);
    end
    push_fips(10);
    reset = 1'b0;
    step();
    bus.key_valid = 1'b0;
    check("rel_accept_valid", {127'd0, bus.rk_valid}, 128'd1);
    for (int i = 0; i < 10; i++) step();
    step();
    check("rel_valid_end", {127'd0, bus.rk_valid}, 128'd0);

    step();
    step();
    check("scoreboard_drained", 128'(sb.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
